// File: rtl/fadc_seq_ctrl.sv
// Sequencer for a multi-channel flash ADC: scans enabled channels, drives the
// track/latch strobes, averages 2^avg_eff thermometer samples per result.
module fadc_seq_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int ADC_BITS   = 4,
  parameter int AVG_MAX    = 3,
  parameter int SETTLE_CYC = 2,
  localparam int TW  = (1 << ADC_BITS) - 1,
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW  = ADC_BITS + AVG_MAX,
  localparam int SW  = AVG_MAX + 1,
  localparam int STW = $clog2(SETTLE_CYC + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                mode_cont,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [1:0]          avg_log2,
  input  logic [TW-1:0]       therm,
  output logic [CW-1:0]       adc_sel,
  output logic                adc_sample,
  output logic                adc_latch,
  output logic [ADC_BITS-1:0] dout,
  output logic [CW-1:0]       dout_ch,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic                err_bubble,
  output logic [2:0]          dbg_state
);

  // dout/dout_ch are offered with dout_valid and held until the cycle where
  // dout_valid && dout_ready is seen at a rising edge; that edge is the transfer.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [1:0]          avg_eff;
  logic [AW-1:0]       acc;
  logic [SW-1:0]       cnt;
  logic [STW-1:0]      settle_cnt;
  logic [TW-1:0]       therm_q;

  logic [CW-1:0]       first_ch;
  logic                first_found;
  logic [CW-1:0]       wrap_ch;
  logic [CW-1:0]       next_ch;
  logic                next_found;
  logic [1:0]          avg_in_eff;
  logic [ADC_BITS-1:0] pop;
  logic [AW-1:0]       acc_sum;
  logic [SW-1:0]       cnt_inc;
  logic [SW-1:0]       cnt_target;
  logic [TW-1:0]       therm_inc;
  logic                bubble;

  assign dbg_state = state;

  // Priority scans: iterate downward so the lowest qualifying index wins.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    wrap_ch     = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CW'(i);
      end
      if (mask_q[i]) begin
        wrap_ch = CW'(i);
        if (i > int'(adc_sel)) begin
          next_found = 1'b1;
          next_ch    = CW'(i);
        end
      end
    end
  end

  always_comb begin
    avg_in_eff = (int'(avg_log2) > AVG_MAX) ? 2'(AVG_MAX) : avg_log2;
    pop        = ADC_BITS'($countones(therm_q));
    acc_sum    = acc + AW'(pop);
    cnt_inc    = cnt + SW'(1);
    cnt_target = SW'(1) << avg_eff;
    // A valid thermometer code is 2^k-1; adding one clears every set bit.
    therm_inc  = therm_q + TW'(1);
    bubble     = |(therm_q & therm_inc);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      avg_eff    <= '0;
      acc        <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      therm_q    <= '0;
      adc_sel    <= '0;
      adc_sample <= 1'b0;
      adc_latch  <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      err_bubble <= 1'b0;
    end else if (stop) begin
      state      <= S_IDLE;
      adc_sample <= 1'b0;
      adc_latch  <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && first_found) begin
            state      <= S_SAMPLE;
            mask_q     <= ch_mask;
            avg_eff    <= avg_in_eff;
            acc        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            adc_sel    <= first_ch;
            adc_sample <= 1'b1;
            busy       <= 1'b1;
            err_bubble <= 1'b0;
          end
        end
        S_SAMPLE: begin
          if (settle_cnt == STW'(SETTLE_CYC - 1)) begin
            state      <= S_CONVERT;
            adc_sample <= 1'b0;
            adc_latch  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + STW'(1);
          end
        end
        S_CONVERT: begin
          therm_q   <= therm;
          adc_latch <= 1'b0;
          state     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          acc <= acc_sum;
          cnt <= cnt_inc;
          if (bubble) err_bubble <= 1'b1;
          if (cnt_inc == cnt_target) begin
            dout       <= ADC_BITS'(acc_sum >> avg_eff);
            dout_ch    <= adc_sel;
            dout_valid <= 1'b1;
            state      <= S_OUTPUT;
          end else begin
            settle_cnt <= '0;
            adc_sample <= 1'b1;
            state      <= S_SAMPLE;
          end
        end
        S_OUTPUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            if (next_found) begin
              adc_sel    <= next_ch;
              adc_sample <= 1'b1;
              state      <= S_SAMPLE;
            end else if (mode_cont) begin
              adc_sel    <= wrap_ch;
              adc_sample <= 1'b1;
              state      <= S_SAMPLE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          adc_sample <= 1'b0;
          adc_latch  <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fadc_seq_ctrl.md
FADC_SEQ_CTRL -- requirements
Module: fadc_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of flash-ADC input channels, 2..16.
REQ-002 SHALL have parameter ADC_BITS, default 4: result width; thermometer width TW = 2^ADC_BITS-1.
REQ-003 SHALL have parameter AVG_MAX, default 3: maximum log2 of the averaging count.
REQ-004 SHALL have parameter SETTLE_CYC, default 2: track/hold settle cycles, >=1.
REQ-005 SHALL have port clk  in  1: single clock; all logic on the rising edge.
REQ-006 SHALL have port resetn  in  1: synchronous, active-low reset.
REQ-007 SHALL have port start  in  1: pad; a one-cycle pulse starts a sweep.
REQ-008 SHALL have port stop  in  1: pad; abort.
REQ-009 SHALL have port mode_cont  in  1: scan; 1 = continuous sweeps.
REQ-010 SHALL have port ch_mask  in  NUM_CH: scan; channel enables.
REQ-011 SHALL have port avg_log2  in  2: scan; log2 of samples averaged per result.
REQ-012 SHALL have port therm  in  TW: full-custom comparator thermometer code.
REQ-013 SHALL have port adc_sel  out  clog2(NUM_CH): full-custom channel mux select.
REQ-014 SHALL have port adc_sample  out  1: full-custom track enable.
REQ-015 SHALL have port adc_latch  out  1: full-custom comparator latch strobe.
REQ-016 SHALL have port dout  out  ADC_BITS: averaged result.
REQ-017 SHALL have port dout_ch  out  clog2(NUM_CH): channel of dout.
REQ-018 SHALL have port dout_valid  out  1: result valid.
REQ-019 SHALL have port dout_ready  in  1: consumer accept.
REQ-020 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-021 SHALL have port err_bubble  out  1: sticky flag for a non-monotonic thermometer code.

Function
REQ-022 SHALL implement states IDLE, SAMPLE, CONVERT, CAPTURE and OUTPUT.
REQ-023 IDLE: start=1 and ch_mask!=0 -> SAMPLE on the lowest enabled channel; latch ch_mask and avg_eff = min(avg_log2, AVG_MAX); clear the accumulator and sample count.
REQ-024 IDLE: start with ch_mask=0 SHALL be ignored; start in any non-IDLE state SHALL be ignored.
REQ-025 SAMPLE: adc_sample=1 for exactly SETTLE_CYC cycles, then -> CONVERT.
REQ-026 CONVERT: adc_latch=1 for one cycle -> CAPTURE.
REQ-027 CAPTURE: register therm; add popcount(therm) to an accumulator of width ADC_BITS+AVG_MAX; increment the sample count.
REQ-028 CAPTURE: if the sample count reaches 2^avg_eff -> OUTPUT, else -> SAMPLE.
REQ-029 dout SHALL equal the accumulator >> avg_eff, truncated; an all-ones sum SHALL give 2^ADC_BITS-1, with no overflow.
REQ-030 err_bubble SHALL set when a captured therm has a 1 above any 0; it SHALL clear only on reset or a start that is accepted in IDLE.
REQ-031 OUTPUT: dout_valid=1; dout and dout_ch SHALL stay stable until dout_valid && dout_ready.
REQ-032 On the OUTPUT handshake: next enabled channel above the current one -> SAMPLE on it, accumulator cleared.
REQ-033 On the OUTPUT handshake with no higher enabled channel (sweep end): if mode_cont=1 (sampled that cycle), wrap to the lowest enabled channel -> SAMPLE; otherwise -> IDLE.
REQ-034 adc_sel SHALL hold the current channel in SAMPLE, CONVERT and CAPTURE, and SHALL be constant within one result.
REQ-035 stop=1 in any state SHALL force IDLE next cycle: dout_valid drops and the pending result is discarded; stop has priority over a simultaneous start or handshake.
REQ-036 With avg_eff=0 and SETTLE_CYC=2: start at cycle 0 -> SAMPLE cycles 1-2, CONVERT 3, CAPTURE 4, dout_valid=1 at cycle 5.

Reset
REQ-037 resetn=0 at a clock edge SHALL force IDLE, including mid-sweep, and discard the accumulator.
REQ-038 resetn=0 SHALL zero dout, dout_ch, adc_sel, dout_valid, adc_sample, adc_latch, busy and err_bubble.
REQ-039 The latched configuration SHALL reset to ch_mask=0 and avg_eff=0.

Verification
REQ-040 Defaults; ch_mask=4'b0101, avg_log2=0, mode_cont=0; therm=15'h007F; dout_ready=1; start pulse -> dout=7, dout_ch=0 at cycle 5; dout=7, dout_ch=2 at cycle 10; then IDLE, busy=0.
REQ-041 avg_log2=2; therm alternates 15'h000F / 15'h001F; ch_mask=4'b0001 -> one result after 4 samples, dout=4 ((4+5+4+5)>>2); adc_sel=0 throughout.
REQ-042 dout_ready=0 for 10 cycles in OUTPUT -> dout_valid stays 1, dout and dout_ch unchanged; no adc_sample pulse until the handshake.
REQ-043 mode_cont=1, ch_mask=4'b1000 -> repeated results on ch3; mode_cont=0 before a handshake -> IDLE after that result; stop mid-SAMPLE -> IDLE next cycle, no dout_valid.
REQ-044 therm=15'h0005 captured -> err_bubble=1 and dout=2; err_bubble stays 1 until the next accepted start.
REQ-045 start with ch_mask=0 -> busy stays 0; resetn=0 during CONVERT -> all outputs 0 next cycle; avg_log2=3 with therm=15'h7FFF -> dout=15.
